bip_program_loader: RTL and testbench
=====================================

Name: bip_program_loader

Overview:
Writes BIP program memory from a byte stream delivered by the UART receiver, then releases the CPU to run it. It assembles byte pairs into 16-bit instructions (opcode[15:11], operand[10:0]) and writes them to consecutive program addresses starting at 0. After the HALT instruction it pulses a CPU reset, then holds the CPU enable high until the control unit reports finish_program. It sits between the UART receiver and the program-memory write port and drives the control unit's BIP_enable and reset inputs.

Parameters:
ADDR_W, 11, program memory address width; must match PC width.
INST_W, 16, instruction width; must equal 2*8.
OPCODE_W, 5, opcode field width (instruction MSBs).
HALT_OPCODE, 5'd0, opcode that terminates a program load.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
rx_data  in  8  received byte; valid only while rx_done=1.
rx_done  in  1  one-cycle strobe: new byte on rx_data.
finish_program  in  1  level from control unit: HALT executed.
prog_wr_en  out  1  program memory write strobe, one cycle per instruction.
prog_wr_addr  out  ADDR_W  program memory write address.
prog_wr_data  out  INST_W  instruction word to write.
bip_reset  out  1  one-cycle reset pulse to control unit and accumulator.
bip_enable  out  1  CPU run enable, drives BIP_enable.
loading  out  1  high from first byte of a load until its final write.
load_done  out  1  high from CPU start until the next load begins.
overflow  out  1  sticky: memory filled without HALT; cleared by the next load or reset.

Behaviour:
- Reset (clk edge with reset=1): state=WAIT_HI, addr=0, hi byte=0. All outputs 0.
- States: WAIT_HI, WAIT_LO, WRITE, START, RUN, DONE.
- WAIT_HI: on rx_done, latch rx_data as instruction[15:8] and go to WAIT_LO. loading=1 from the next cycle.
- WAIT_LO: on rx_done, latch rx_data as instruction[7:0] and go to WRITE.
- WRITE (exactly one cycle): prog_wr_en=1, prog_wr_addr=addr, prog_wr_data={hi,lo}. Byte-to-write latency is 1 cycle after the lo-byte strobe. Next state:
  - opcode==HALT_OPCODE: go to START. addr holds.
  - otherwise, addr==2^ADDR_W-1: set overflow=1, go to START.
  - otherwise: addr+1. If rx_done=1 in this cycle, latch it as the next hi byte and go to WAIT_LO; else go to WAIT_HI.
- START (one cycle): bip_reset=1, loading=0, load_done=1. Next state is RUN.
- RUN: bip_enable=1. When finish_program=1, go to DONE; bip_enable=0 from the next cycle. In START and RUN, rx_done is ignored.
- DONE: bip_enable=0, load_done=1. On rx_done, start a new load: addr=0, overflow=0, load_done=0, latch the byte as hi, go to WAIT_LO.
- rx_done in START or RUN is dropped. The host must wait for load_done before sending.
- finish_program outside RUN is ignored.
- reset in any state returns to the reset condition on that edge and aborts any in-flight pair. A WRITE in progress on that edge is suppressed (prog_wr_en=0).
- No address wrap: addr never exceeds 2^ADDR_W-1.

Decomposition:
- Shared package/header holds:
  - state encoding: 3-bit localparams.
  - OPCODE_W, ADDR_W, INST_W.
  - HALT_OPCODE, shared with the Decoder opcode table.
- Single module. No sub-module is needed: the address counter and byte assembler are each a few lines.

Test Plan:
- Load bytes 08 05, 10 03, 00 00 (each rx_done 10 cycles apart) -> writes addr0=0x0805, addr1=0x1003, addr2=0x0000. Then bip_reset pulses one cycle, bip_enable=1, load_done=1.
- In RUN, raise finish_program -> bip_enable=0 on the next cycle; state DONE; load_done stays 1.
- From DONE, send 18 01, 00 00 -> addr restarts: addr0=0x1801, addr1=0x0000; load_done=0 during the load; second run starts.
- rx_done asserted in the WRITE cycle of pair 1 with 0x20 -> pair 2 hi=0x20; no byte lost; addresses consecutive.
- 2048 non-HALT instructions (opcode 1) -> last write at addr 0x7FF, overflow=1, CPU started, no write to addr 0.
- reset asserted between hi and lo byte -> no write; next pair is written to addr 0; all outputs 0 on the reset edge.

Source files
------------

// File: rtl/bip_program_loader_pkg.sv
// Shared constants and FSM encoding for the BIP program loader.
// HALT_OPCODE must stay in step with the decoder's opcode table.
package bip_program_loader_pkg;

    localparam int ADDR_W   = 11;
    localparam int INST_W   = 16;
    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'd0;

    typedef enum logic [2:0] {
        ST_WAIT_HI = 3'd0,
        ST_WAIT_LO = 3'd1,
        ST_WRITE   = 3'd2,
        ST_START   = 3'd3,
        ST_RUN     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/bip_program_loader.sv
// Assembles UART byte pairs into BIP instructions, writes them to program memory,
// then pulses the CPU reset and holds the CPU enabled until the program finishes.
module bip_program_loader #(
    parameter int ADDR_W   = bip_program_loader_pkg::ADDR_W,
    parameter int INST_W   = bip_program_loader_pkg::INST_W,
    parameter int OPCODE_W = bip_program_loader_pkg::OPCODE_W,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = bip_program_loader_pkg::HALT_OPCODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              finish_program,
    output logic              prog_wr_en,
    output logic [ADDR_W-1:0] prog_wr_addr,
    output logic [INST_W-1:0] prog_wr_data,
    output logic              bip_reset,
    output logic              bip_enable,
    output logic              loading,
    output logic              load_done,
    output logic              overflow
);
    import bip_program_loader_pkg::*;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_hi;
    logic [7:0]          r_lo;
    logic                r_loading;
    logic                r_overflow;
    logic [INST_W-1:0]   w_inst;
    logic                w_is_halt;
    logic                w_addr_full;

    assign w_inst      = {r_hi, r_lo};
    assign w_is_halt   = (w_inst[INST_W-1 -: OPCODE_W] == HALT_OPCODE);
    assign w_addr_full = (r_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_WAIT_HI;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_WAIT_HI: if (rx_done) w_next_state = ST_WAIT_LO;
            ST_WAIT_LO: if (rx_done) w_next_state = ST_WRITE;
            ST_WRITE: begin
                if (w_is_halt || w_addr_full) w_next_state = ST_START;
                else if (rx_done)             w_next_state = ST_WAIT_LO;
                else                          w_next_state = ST_WAIT_HI;
            end
            ST_START:   w_next_state = ST_RUN;
            ST_RUN:     if (finish_program) w_next_state = ST_DONE;
            ST_DONE:    if (rx_done) w_next_state = ST_WAIT_LO;
            default:    w_next_state = ST_WAIT_HI;
        endcase
    end

    // NOTE: all datapath registers are few and must start clean, so each one is reset here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_loading  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_HI: if (rx_done) begin
                    r_hi      <= rx_data;
                    r_loading <= 1'b1;
                end
                ST_WAIT_LO: if (rx_done) r_lo <= rx_data;
                ST_WRITE: begin
                    if (w_is_halt) begin
                        r_loading <= 1'b0;
                    end else if (w_addr_full) begin
                        r_overflow <= 1'b1;
                        r_loading  <= 1'b0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        // A byte landing in the write cycle is the next pair's high half.
                        if (rx_done) r_hi <= rx_data;
                    end
                end
                ST_DONE: if (rx_done) begin
                    r_addr     <= '0;
                    r_overflow <= 1'b0;
                    r_hi       <= rx_data;
                    r_loading  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are gated by reset so a write or pulse in flight on the reset edge is dropped.
    assign prog_wr_en   = (r_state == ST_WRITE) && !reset;
    assign prog_wr_addr = r_addr;
    assign prog_wr_data = w_inst;
    assign bip_reset    = (r_state == ST_START) && !reset;
    assign bip_enable   = (r_state == ST_RUN) && !reset;
    assign load_done    = ((r_state == ST_START) || (r_state == ST_RUN) || (r_state == ST_DONE)) && !reset;
    assign loading      = r_loading && !reset;
    assign overflow     = r_overflow && !reset;

endmodule

// File: tb/tb_bip_program_loader.sv
// Randomized self-checking bench for bip_program_loader against a program-level model.
module tb_bip_program_loader;

    localparam int MEM_DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        finish_program;
    logic        prog_wr_en;
    logic [10:0] prog_wr_addr;
    logic [15:0] prog_wr_data;
    logic        bip_reset;
    logic        bip_enable;
    logic        loading;
    logic        load_done;
    logic        overflow;

    always #5 clk = ~clk;

    bip_program_loader dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .finish_program (finish_program),
        .prog_wr_en     (prog_wr_en),
        .prog_wr_addr   (prog_wr_addr),
        .prog_wr_data   (prog_wr_data),
        .bip_reset      (bip_reset),
        .bip_enable     (bip_enable),
        .loading        (loading),
        .load_done      (load_done),
        .overflow       (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Every memory write and every CPU reset pulse, sampled on the falling edge.
    logic [10:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          n_bip_reset = 0;

    always @(negedge clk) begin
        if (prog_wr_en) begin
            wa_q.push_back(prog_wr_addr);
            wd_q.push_back(prog_wr_data);
        end
        if (bip_reset) n_bip_reset++;
    end

    logic [15:0] prog_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},      prog_wr_en, 0);
        check({tag, "_bip_reset"},  bip_reset,  0);
        check({tag, "_bip_enable"}, bip_enable, 0);
        check({tag, "_loading"},    loading,    0);
        check({tag, "_load_done"},  load_done,  0);
        check({tag, "_overflow"},   overflow,   0);
    endtask

    // Sends prog_q as a host would and checks the resulting writes and CPU start.
    task automatic run_load(input string tag, input int gap_min, input int gap_max);
        int  n_wr_exp;
        bit  halt_seen;
        bit  ovf_exp;
        bit  seen;
        bit  detail;
        int  pulses0;
        wa_q.delete();
        wd_q.delete();
        pulses0   = n_bip_reset;
        n_wr_exp  = 0;
        halt_seen = 1'b0;
        foreach (prog_q[i]) begin
            if (n_wr_exp == MEM_DEPTH) break;
            n_wr_exp++;
            if (prog_q[i][15:11] == 5'd0) begin
                halt_seen = 1'b1;
                break;
            end
        end
        ovf_exp = !halt_seen && (n_wr_exp == MEM_DEPTH);

        for (int i = 0; i < n_wr_exp; i++) begin
            detail = (n_wr_exp <= 64) || (i < 2) || (i >= n_wr_exp - 2);
            send_byte(prog_q[i][15:8]);
            if (i == 0) begin
                check({tag, "_load_done_during"}, load_done, 0);
                check({tag, "_overflow_cleared"}, overflow,  0);
            end
            if (detail) check({tag, "_loading_hi"}, loading, 1);
            idle($urandom_range(gap_max, gap_min));
            send_byte(prog_q[i][7:0]);
            if (detail) begin
                check({tag, "_wr_en_latency"}, prog_wr_en,   1);
                check({tag, "_wr_addr_live"},  prog_wr_addr, i);
                check({tag, "_wr_data_live"},  prog_wr_data, prog_q[i]);
            end
            if (i != n_wr_exp - 1) idle($urandom_range(gap_max, gap_min));
        end

        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (load_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_load_done_seen"}, seen, 1);
        check({tag, "_start_bip_reset"},  bip_reset,  1);
        check({tag, "_start_bip_enable"}, bip_enable, 0);
        check({tag, "_start_loading"},    loading,    0);
        check({tag, "_start_overflow"},   overflow,   ovf_exp);
        step();
        check({tag, "_run_bip_reset"},  bip_reset,  0);
        check({tag, "_run_bip_enable"}, bip_enable, 1);
        check({tag, "_run_load_done"},  load_done,  1);
        idle(2);
        check({tag, "_reset_pulses"}, n_bip_reset - pulses0, 1);

        check({tag, "_write_count"}, wa_q.size(), n_wr_exp);
        for (int i = 0; i < n_wr_exp && i < wa_q.size(); i++) begin
            check({tag, "_wr_addr"}, wa_q[i], i);
            check({tag, "_wr_data"}, wd_q[i], prog_q[i]);
        end
    endtask

    task automatic finish_run(input string tag);
        check({tag, "_enable_before_finish"}, bip_enable, 1);
        finish_program = 1'b1;
        step();
        finish_program = 1'b0;
        check({tag, "_enable_after_finish"}, bip_enable, 0);
        check({tag, "_done_load_done"},      load_done,  1);
        step();
        check({tag, "_done_enable_stays_0"}, bip_enable, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sz;
        reset          = 1'b1;
        rx_done        = 1'b0;
        rx_data        = 8'h00;
        finish_program = 1'b0;
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check_all_zero("post_reset");
        check("post_reset_addr", prog_wr_addr, 0);
        check("post_reset_data", prog_wr_data, 0);

        finish_program = 1'b1;
        step();
        finish_program = 1'b0;
        check("finish_outside_run_done",   load_done,  0);
        check("finish_outside_run_enable", bip_enable, 0);

        prog_q = '{16'h0805, 16'h1003, 16'h0000};
        run_load("dir1", 9, 9);

        sz = wa_q.size();
        send_byte(8'h55);
        send_byte(8'h66);
        idle(3);
        check("run_bytes_dropped", wa_q.size(), sz);
        check("run_enable_held", bip_enable, 1);
        finish_run("dir1");

        prog_q = '{16'h1801, 16'h0000};
        run_load("dir2", 2, 2);
        finish_run("dir2");

        prog_q = '{16'h0807, 16'h2011, 16'h0000};
        run_load("write_cycle_byte", 0, 0);
        finish_run("write_cycle_byte");

        for (int t = 0; t < 8; t++) begin
            prog_q.delete();
            n = $urandom_range(10, 1);
            for (int k = 0; k < n - 1; k++)
                prog_q.push_back({5'($urandom_range(31, 1)), 11'($urandom)});
            prog_q.push_back({5'd0, 11'($urandom)});
            run_load("rnd", 0, 3);
            finish_run("rnd");
        end

        prog_q.delete();
        for (int k = 0; k < MEM_DEPTH; k++)
            prog_q.push_back({5'd1, 11'($urandom)});
        run_load("ovf", 0, 0);
        finish_run("ovf");
        check("ovf_sticky_in_done", overflow, 1);

        prog_q = '{16'h3C3C, 16'h0000};
        run_load("ovf_clear", 1, 2);
        finish_run("ovf_clear");

        wa_q.delete();
        send_byte(8'h08);
        send_byte(8'h11);
        check("pre_rst_write", prog_wr_en, 1);
        send_byte(8'h09);
        reset = 1'b1;
        step();
        check_all_zero("mid_pair_reset");
        reset = 1'b0;
        step();
        check_all_zero("mid_pair_after");
        check("mid_pair_writes", wa_q.size(), 1);
        prog_q = '{16'h0A55, 16'h0000};
        run_load("after_rst", 1, 2);
        finish_run("after_rst");

        wa_q.delete();
        send_byte(8'h10);
        send_byte(8'h22);
        reset = 1'b1;
        #1;
        check("write_suppressed_by_reset", prog_wr_en, 0);
        step();
        reset = 1'b0;
        idle(2);
        check("write_reset_no_write", wa_q.size(), 0);
        prog_q = '{16'h0000};
        run_load("after_wr_rst", 1, 1);
        finish_run("after_wr_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
